// File: rtl/uart_pkg.sv
// Shared UART types and constants: tx FSM states, data/stop limits, line idle level, parity helper.
package uart_pkg;

  localparam int unsigned DATA_BITS_MAX = 8;
  localparam int unsigned STOP_BITS_MAX = 2;
  localparam logic        LINE_IDLE     = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // Parity over the bits that will actually be sent; bit 7 dropped in 7-bit mode.
  function automatic logic parity_bit(input logic [DATA_BITS_MAX-1:0] d,
                                      input logic bit8, input logic odd);
    logic [DATA_BITS_MAX-1:0] m;
    m = d;
    if (!bit8) m[DATA_BITS_MAX-1] = 1'b0;
    return (^m) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_hold.sv
// One-entry holding register between the valid/ready byte interface and the serializer.
module uart_tx_hold
  import uart_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_BITS_MAX-1:0] data_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic                     unload_i,
  output logic [DATA_BITS_MAX-1:0] data_o
);

  logic                     ready_q;
  logic [DATA_BITS_MAX-1:0] data_q;

  // Unload is only requested while full, so it never collides with an accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q <= 1'b1;
      data_q  <= '0;
    end else if (valid_i && ready_q) begin
      ready_q <= 1'b0;
      data_q  <= data_i;
    end else if (unload_i) begin
      ready_q <= 1'b1;
    end
  end

  assign ready_o = ready_q;
  assign data_o  = data_q;

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit FSM: start, 7/8 data bits LSB first, optional parity, STOP_BITS stop bits.
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     xmit_pulse,
  input  logic [DATA_BITS_MAX-1:0] tx_data,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  input  logic                     bit8,
  input  logic                     parity_en,
  input  logic                     odd_n_even,
  output logic                     tx,
  output logic                     tx_busy
);

  localparam int unsigned CNT_W  = $clog2(DATA_BITS_MAX);
  localparam int unsigned STOP_W = $clog2(STOP_BITS_MAX);
  localparam logic [CNT_W-1:0]  LAST8     = CNT_W'(DATA_BITS_MAX - 1);
  localparam logic [CNT_W-1:0]  LAST7     = CNT_W'(DATA_BITS_MAX - 2);
  localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(STOP_BITS - 1);

  tx_state_e                state_q, state_d;
  logic [DATA_BITS_MAX-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [STOP_W-1:0]        stop_q, stop_d;
  logic                     bit8_q, bit8_d;
  logic                     tx_q, tx_d;
  logic                     busy_q;
  logic                     start_frame_c;
  logic                     unload_c;
  logic                     hold_ready;
  logic [DATA_BITS_MAX-1:0] hold_data;
`ifdef UART_TX_PARITY_EN
  logic                     par_en_q, par_en_d;
  logic                     par_q, par_d;
`else
  logic                     unused_cfg;
  assign unused_cfg = parity_en ^ odd_n_even;
`endif

  uart_tx_hold u_hold (
    .clk      (clk),
    .reset    (reset),
    .data_i   (tx_data),
    .valid_i  (tx_valid),
    .ready_o  (hold_ready),
    .unload_i (unload_c),
    .data_o   (hold_data)
  );

  // State register; reset abandons any frame and drives the line idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      stop_q   <= '0;
      bit8_q   <= 1'b1;
      tx_q     <= LINE_IDLE;
      busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      stop_q   <= stop_d;
      bit8_q   <= bit8_d;
      tx_q     <= tx_d;
      busy_q   <= (state_d != IDLE);
`ifdef UART_TX_PARITY_EN
      par_en_q <= par_en_d;
      par_q    <= par_d;
`endif
    end
  end

  // Next state; everything advances only on the bit-period strobe.
  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    cnt_d         = cnt_q;
    stop_d        = stop_q;
    bit8_d        = bit8_q;
    tx_d          = tx_q;
    start_frame_c = 1'b0;
    unload_c      = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_d      = par_en_q;
    par_d         = par_q;
`endif
    if (xmit_pulse) begin
      case (state_q)
        IDLE: begin
          tx_d          = LINE_IDLE;
          start_frame_c = !hold_ready;
        end
        START: begin
          tx_d    = shift_q[0];
          cnt_d   = '0;
          state_d = DATA;
        end
        DATA: begin
          if (cnt_q == (bit8_q ? LAST8 : LAST7)) begin
            state_d = STOP;
            tx_d    = LINE_IDLE;
            stop_d  = '0;
`ifdef UART_TX_PARITY_EN
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = par_q;
            end
`endif
          end else begin
            shift_d = shift_q >> 1;
            cnt_d   = cnt_q + CNT_W'(1);
            tx_d    = shift_q[1];
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          state_d = STOP;
          tx_d    = LINE_IDLE;
          stop_d  = '0;
        end
`endif
        STOP: begin
          if (stop_q == STOP_LAST) begin
            state_d       = IDLE;
            tx_d          = LINE_IDLE;
            start_frame_c = !hold_ready;
          end else begin
            stop_d = stop_q + STOP_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          tx_d    = LINE_IDLE;
        end
      endcase
    end
    // Frame start (from IDLE or straight out of the last stop bit) latches byte and config.
    if (start_frame_c) begin
      unload_c = 1'b1;
      shift_d  = hold_data;
      bit8_d   = bit8;
      tx_d     = ~LINE_IDLE;
      state_d  = START;
`ifdef UART_TX_PARITY_EN
      par_en_d = parity_en;
      par_d    = parity_bit(hold_data, bit8, odd_n_even);
`endif
    end
  end

  assign tx       = tx_q;
  assign tx_busy  = busy_q;
  assign tx_ready = hold_ready;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: one instance with 1 stop bit, one with 2.
module tb_uart_tx_serializer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       xmit_pulse = 1'b0;
  logic       bit8 = 1'b1;
  logic       parity_en = 1'b0;
  logic       odd_n_even = 1'b0;
  logic [7:0] tx_data0 = '0, tx_data1 = '0;
  logic       tx_valid0 = 1'b0, tx_valid1 = 1'b0;
  logic       tx_ready0, tx_ready1, tx0, tx1, tx_busy0, tx_busy1;

  int period = 16;
  int pcnt = 0;
  int tests_run = 0;
  int tests_failed = 0;
  bit mon_en [2];

  typedef struct {
    logic [15:0] bits;
    int          len;
    bit          b2b;
  } frame_t;

  frame_t q0[$];
  frame_t q1[$];

  always #5 clk = ~clk;

  uart_tx_serializer #(.STOP_BITS(1)) u_dut0 (
    .clk(clk), .reset(reset), .xmit_pulse(xmit_pulse), .tx_data(tx_data0),
    .tx_valid(tx_valid0), .tx_ready(tx_ready0), .bit8(bit8), .parity_en(parity_en),
    .odd_n_even(odd_n_even), .tx(tx0), .tx_busy(tx_busy0));

  uart_tx_serializer #(.STOP_BITS(2)) u_dut1 (
    .clk(clk), .reset(reset), .xmit_pulse(xmit_pulse), .tx_data(tx_data1),
    .tx_valid(tx_valid1), .tx_ready(tx_ready1), .bit8(bit8), .parity_en(parity_en),
    .odd_n_even(odd_n_even), .tx(tx1), .tx_busy(tx_busy1));

  // Bit-period strobe, one clock wide every `period` clocks.
  initial forever begin
    @(negedge clk);
    if (pcnt + 1 >= period) begin
      xmit_pulse = 1'b1;
      pcnt = 0;
    end else begin
      xmit_pulse = 1'b0;
      pcnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic rdy(input int idx);
    return (idx != 0) ? tx_ready1 : tx_ready0;
  endfunction

  function automatic logic bsy(input int idx);
    return (idx != 0) ? tx_busy1 : tx_busy0;
  endfunction

  function automatic int qsize(input int idx);
    return (idx != 0) ? q1.size() : q0.size();
  endfunction

  function automatic frame_t build(input logic [7:0] d, input bit b8, input bit pe,
                                   input bit odd, input int stops, input bit b2b);
    frame_t f;
    int n;
    int ones;
    bit par_on;
    f.bits = '0;
    f.b2b  = b2b;
    n = 1;
    ones = 0;
    for (int i = 0; i < (b8 ? 8 : 7); i++) begin
      f.bits[n] = d[i];
      ones += int'(d[i]);
      n++;
    end
`ifdef UART_TX_PARITY_EN
    par_on = pe;
`else
    par_on = pe & 1'b0;
`endif
    if (par_on) begin
      f.bits[n] = ((ones % 2) == 1) ^ odd;
      n++;
    end
    for (int i = 0; i < stops; i++) begin
      f.bits[n] = 1'b1;
      n++;
    end
    f.len = n;
    return f;
  endfunction

  // Monitor: samples the line after each strobe and checks whole frames against the queue.
  task automatic mon(input int idx);
    int st = 0, n = 0, gap = 100;
    frame_t cur;
    logic [15:0] got = '0;
    logic prev = 1'b1, s, b;
    bit glitch = 0, busy_bad = 0, chk_busy = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!mon_en[idx]) begin
        st = 0; gap = 100; chk_busy = 0; prev = 1'b1; glitch = 0;
        continue;
      end
      s = (idx != 0) ? tx1 : tx0;
      b = bsy(idx);
      if (!xmit_pulse) begin
        if (s !== prev) glitch = 1;
        continue;
      end
      if (st == 0) begin
        if (s === 1'b0) begin
          if (qsize(idx) == 0) begin
            check("frame_expected", 0, 1);
            cur.bits = '0; cur.len = 10; cur.b2b = 0;
          end else if (idx != 0) cur = q1.pop_front();
          else cur = q0.pop_front();
          if (cur.b2b) check("b2b_gap", gap, 0);
          got = '0; n = 1; busy_bad = !b; st = 1; chk_busy = 0;
        end else begin
          if (chk_busy) check("busy_drop", b, 0);
          chk_busy = 0;
          gap++;
        end
      end else begin
        got[n] = s;
        if (b !== 1'b1) busy_bad = 1;
        n++;
        if (n == cur.len) begin
          check("frame_bits", got, cur.bits);
          check("frame_hold_busy", {glitch, busy_bad}, 0);
          st = 0; gap = 0; chk_busy = 1; glitch = 0;
        end
      end
      prev = s;
    end
  endtask

  // Offer a byte; on accept, push its expected frame and confirm tx_ready drops.
  task automatic send(input int idx, input logic [7:0] d, input bit b8, input bit pe,
                      input bit odd, input bit b2b, input bit push);
    bit ok = 0;
    @(negedge clk);
    bit8 = b8; parity_en = pe; odd_n_even = odd;
    if (idx != 0) begin tx_data1 = d; tx_valid1 = 1'b1; end
    else begin tx_data0 = d; tx_valid0 = 1'b1; end
    for (int i = 0; i < 3000 && !ok; i++) begin
      if (rdy(idx)) begin
        @(posedge clk);
        ok = 1;
        if (push) begin
          if (idx != 0) q1.push_back(build(d, b8, pe, odd, 2, b2b));
          else q0.push_back(build(d, b8, pe, odd, 1, b2b));
        end
        #1 check("ready_drop", rdy(idx), 0);
      end
      @(negedge clk);
    end
    if (idx != 0) tx_valid1 = 1'b0; else tx_valid0 = 1'b0;
    check("accept_timeout", ok, 1);
  endtask

  task automatic wait_idle(input int idx);
    bit done = 0;
    for (int i = 0; i < 6000 && !done; i++) begin
      @(negedge clk);
      if (qsize(idx) == 0 && !bsy(idx)) done = 1;
    end
    check("idle_timeout", done, 1);
    repeat (40) @(negedge clk);
  endtask

  initial begin
    int cnt;
    bit seen;
    mon_en[0] = 0; mon_en[1] = 0;
    fork
      mon(0);
      mon(1);
    join_none
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", tx0, 1);
    check("reset_busy", tx_busy0, 0);
    check("reset_ready", tx_ready0, 1);
    @(negedge clk);
    reset = 1'b0;
    mon_en[0] = 1; mon_en[1] = 1;

    send(0, 8'h55, 1, 0, 0, 0, 1);
    wait_idle(0);
    send(0, 8'h41, 0, 1, 1, 0, 1);
    wait_idle(0);
    send(0, 8'hA3, 1, 0, 0, 0, 1);
    send(0, 8'h3C, 1, 0, 0, 1, 1);
    wait_idle(0);

    // Stalled producer: hold stays full, so tx_ready must stay low.
    send(0, 8'h80, 1, 1, 0, 0, 1);
    send(0, 8'h12, 1, 1, 0, 1, 1);
    @(negedge clk);
    tx_data0 = 8'h34; tx_valid0 = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_ready0 !== 1'b0) seen = 1;
    end
    check("stall_ready_low", seen, 0);
    send(0, 8'h34, 1, 1, 0, 1, 1);
    wait_idle(0);

    send(1, 8'hFF, 1, 0, 0, 0, 1);
    wait_idle(1);

    // Reset mid-DATA with a second byte waiting in hold.
    mon_en[0] = 0;
    send(0, 8'h00, 1, 0, 0, 0, 0);
    send(0, 8'h00, 1, 0, 0, 0, 0);
    cnt = 0;
    for (int i = 0; i < 200 && cnt < 3; i++) begin
      @(posedge clk);
      #1;
      if (xmit_pulse) cnt++;
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_tx", tx0, 1);
    check("midreset_busy", tx_busy0, 0);
    check("midreset_ready", tx_ready0, 1);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx0 !== 1'b1 || tx_busy0 !== 1'b0) seen = 1;
    end
    check("no_frame_after_reset", seen, 0);
    mon_en[0] = 1;

    // Strobe held high: one bit per clock, back-to-back.
    period = 1;
    send(0, 8'h5A, 1, 0, 0, 0, 1);
    send(0, 8'hC3, 1, 0, 0, 1, 1);
    wait_idle(0);
    period = 16;

    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
